// File: rtl/fib_gen_nb.sv
// rtl/fib_gen_nb.sv - Fibonacci term generator with valid/ready output and overflow handling
module fib_gen_nb #(
    parameter int N     = 8,
    parameter int CNT_W = 5,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             out_ready,
    output logic [N-1:0]     fib_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] term_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0]     TERM_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [N-1:0]     a, a_nx, b, b_nx;
    logic             b_c, b_c_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, idx_nx;
    logic             ovf_nx;
    logic [N:0]       sum;
    logic             hs;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign hs      = out_valid & out_ready;
    assign fib_out = a;

    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        b_c_nx   = b_c;
        cnt_nx   = cnt;
        idx_nx   = term_idx;
        ovf_nx   = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nx   = num_terms;
                    a_nx     = '0;
                    b_nx     = TERM_ONE;
                    b_c_nx   = 1'b0;
                    idx_nx   = CNT_ZERO;
                    ovf_nx   = 1'b0;
                    state_nx = (num_terms == CNT_ZERO) ? DONE : GEN;
                end
            end
            GEN: begin
                if (hs) begin
                    if (term_idx == cnt - CNT_ONE) begin
                        state_nx = DONE;
                    end else if (b_c && (WRAP == 0)) begin
                        // The pending term does not fit in N bits: end without showing it.
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        a_nx   = b;
                        b_nx   = sum[N-1:0];
                        b_c_nx = sum[N];
                        idx_nx = term_idx + CNT_ONE;
                        if (b_c) begin
                            ovf_nx = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= TERM_ONE;
            b_c       <= 1'b0;
            cnt       <= CNT_ZERO;
            term_idx  <= CNT_ZERO;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            a         <= a_nx;
            b         <= b_nx;
            b_c       <= b_c_nx;
            cnt       <= cnt_nx;
            term_idx  <= idx_nx;
            ovf       <= ovf_nx;
            // Status flags are registered from the next state so they line up with it.
            out_valid <= (state_nx == GEN);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
        end
    end

endmodule
